snoop_bus_ctrl: RTL and testbench

Shared-bus controller on the responder side of the MESI snooping protocol. It accepts per-cache bus requests (GetS, GetX, Inv, PutX), arbitrates round-robin, and broadcasts the winning request to every other cache's `MESI` snooper as `gets_obs`/`getx_obs`/`inv_obs`. It collects snoop share/flush responses, sequences the memory access, and returns `share` and a completion pulse to the requester. It sits between the per-cache MESI controllers and the memory model.

---
 rtl/snoop_bus_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_ctrl.sv
// Responder-side MESI snooping bus controller: round-robin arbitration, snoop broadcast,
// response collection and memory sequencing. Define SNOOP_BUS_C2C_EN for cache-to-cache transfer.
module snoop_bus_ctrl #(
   parameter int NCACHE  = 4,
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NCACHE-1:0]        req_gets,
   input  logic [NCACHE-1:0]        req_getx,
   input  logic [NCACHE-1:0]        req_inv,
   input  logic [NCACHE-1:0]        req_putx,
   input  logic [NCACHE*ADDR_W-1:0] req_addr,
   input  logic [NCACHE-1:0]        snoop_share,
   input  logic [NCACHE-1:0]        snoop_flush,
   output logic [NCACHE-1:0]        grant,
   output logic [NCACHE-1:0]        gets_obs,
   output logic [NCACHE-1:0]        getx_obs,
   output logic [NCACHE-1:0]        inv_obs,
   output logic [ADDR_W-1:0]        bus_addr,
   output logic                     share,
   output logic [NCACHE-1:0]        done,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic                     busy,
   output logic                     err
);

   localparam int IDX_W = $clog2(NCACHE);
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
`ifdef SNOOP_BUS_C2C_EN
   localparam logic C2C_EN = 1'b1;
`else
   localparam logic C2C_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_SNOOP = 3'd2,
      S_RESP  = 3'd3,
      S_MEM   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      T_GETS = 2'd0,
      T_GETX = 2'd1,
      T_INV  = 2'd2,
      T_PUTX = 2'd3
   } type_t;

   state_t              r_state;
   type_t               r_type;
   logic [IDX_W-1:0]    r_req;
   logic [IDX_W-1:0]    r_rr;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_share_lat;
   logic                r_flush;
   logic [NCACHE-1:0]   r_grant;
   logic [NCACHE-1:0]   r_gets_obs;
   logic [NCACHE-1:0]   r_getx_obs;
   logic [NCACHE-1:0]   r_inv_obs;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic                r_share;
   logic [NCACHE-1:0]   r_done;
   logic                r_mem_rd;
   logic                r_mem_wr;
   logic                r_busy;
   logic                r_err;

   logic [NCACHE-1:0]   w_req_any;
   logic                w_found;
   logic [IDX_W-1:0]    w_pick;
   logic [IDX_W-1:0]    w_idx;
   type_t               w_type;
   logic [NCACHE-1:0]   w_pick_oh;
   logic [ADDR_W-1:0]   w_req_addr;
   logic [NCACHE-1:0]   w_share_m;
   logic [NCACHE-1:0]   w_flush_m;
   logic                w_multi_flush;

   assign w_req_any  = req_gets | req_getx | req_inv | req_putx;
   assign w_pick_oh  = {{(NCACHE-1){1'b0}}, 1'b1} << w_pick;
   assign w_req_addr = req_addr[w_pick*ADDR_W +: ADDR_W];
   assign w_share_m  = snoop_share & ~r_grant;
   assign w_flush_m  = snoop_flush & ~r_grant;
   // Clearing the lowest set bit leaves something only when two or more flushers answered.
   assign w_multi_flush = |(w_flush_m & (w_flush_m - {{(NCACHE-1){1'b0}}, 1'b1}));

   // Round-robin search: first requesting cache at or after r_rr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = 0; k < NCACHE; k++) begin
         w_idx = IDX_W'((int'(r_rr) + k) % NCACHE);
         if (!w_found && w_req_any[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end else begin
            w_found = w_found;
         end
      end
   end

   // Request type of the picked cache, PutX > GetX > Inv > GetS.
   always_comb begin
      w_type = T_GETS;
      if (req_putx[w_pick]) begin
         w_type = T_PUTX;
      end else if (req_getx[w_pick]) begin
         w_type = T_GETX;
      end else if (req_inv[w_pick]) begin
         w_type = T_INV;
      end else begin
         w_type = T_GETS;
      end
   end

   // Transaction FSM; every output is registered on the edge entering its state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_type      <= T_GETS;
         r_req       <= '0;
         r_rr        <= '0;
         r_cnt       <= '0;
         r_share_lat <= 1'b0;
         r_flush     <= 1'b0;
         r_grant     <= '0;
         r_gets_obs  <= '0;
         r_getx_obs  <= '0;
         r_inv_obs   <= '0;
         r_bus_addr  <= '0;
         r_share     <= 1'b0;
         r_done      <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_gets_obs <= '0;
         r_getx_obs <= '0;
         r_inv_obs  <= '0;
         r_done     <= '0;
         r_share    <= 1'b0;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_req       <= w_pick;
                  r_type      <= w_type;
                  r_bus_addr  <= w_req_addr;
                  r_grant     <= w_pick_oh;
                  r_share_lat <= 1'b0;
                  r_flush     <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_GRANT;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            S_GRANT: begin
               if (r_type == T_PUTX) begin
                  r_cnt    <= '0;
                  r_mem_wr <= 1'b1;
                  r_state  <= S_MEM;
               end else begin
                  case (r_type)
                     T_GETX:  r_getx_obs <= ~r_grant;
                     T_INV:   r_inv_obs  <= ~r_grant;
                     default: r_gets_obs <= ~r_grant;
                  endcase
                  r_state <= S_SNOOP;
               end
            end
            S_SNOOP: begin
               // Snoopers answer the broadcast within the SNOOP cycle; the writeback lands in RESP.
               r_share_lat <= |w_share_m;
               r_flush     <= |w_flush_m;
               r_mem_wr    <= (r_type != T_INV) && (|w_flush_m);
               if (w_multi_flush) begin
                  r_err <= 1'b1;
               end else begin
                  r_err <= r_err;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               if ((r_type == T_INV) || (C2C_EN && r_flush)) begin
                  r_done  <= r_grant;
                  r_share <= r_share_lat;
                  r_state <= S_DONE;
               end else begin
                  r_cnt    <= '0;
                  r_mem_rd <= 1'b1;
                  r_state  <= S_MEM;
               end
            end
            S_MEM: begin
               if (r_cnt == CNT_W'(MEM_LAT - 1)) begin
                  r_done  <= r_grant;
                  r_share <= (r_type == T_PUTX) ? 1'b0 : r_share_lat;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (r_req == IDX_W'(NCACHE - 1)) begin
                  r_rr <= '0;
               end else begin
                  r_rr <= r_req + IDX_W'(1);
               end
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign grant    = r_grant;
   assign gets_obs = r_gets_obs;
   assign getx_obs = r_getx_obs;
   assign inv_obs  = r_inv_obs;
   assign bus_addr = r_bus_addr;
   assign share    = r_share;
   assign done     = r_done;
   assign mem_rd   = r_mem_rd;
   assign mem_wr   = r_mem_wr;
   assign busy     = r_busy;
   assign err      = r_err;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed, table-driven bench for snoop_bus_ctrl (NCACHE=4, MEM_LAT=4).
module tb_snoop_bus_ctrl;

   localparam int NC = 4;
   localparam int AW = 32;
   localparam int ML = 4;
`ifdef SNOOP_BUS_C2C_EN
   localparam int FL_RD   = -1;
   localparam int FL_DONE = 4;
`else
   localparam int FL_RD   = 4;
   localparam int FL_DONE = 8;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NC-1:0]     req_gets, req_getx, req_inv, req_putx;
   logic [NC*AW-1:0]  req_addr;
   logic [NC-1:0]     snoop_share, snoop_flush;
   logic [NC-1:0]     grant, gets_obs, getx_obs, inv_obs, done;
   logic [AW-1:0]     bus_addr;
   logic              share, mem_rd, mem_wr, busy, err;

   always #5 clk = ~clk;

   snoop_bus_ctrl #(.NCACHE(NC), .ADDR_W(AW), .MEM_LAT(ML)) dut (
      .clk(clk), .reset(reset),
      .req_gets(req_gets), .req_getx(req_getx), .req_inv(req_inv), .req_putx(req_putx),
      .req_addr(req_addr), .snoop_share(snoop_share), .snoop_flush(snoop_flush),
      .grant(grant), .gets_obs(gets_obs), .getx_obs(getx_obs), .inv_obs(inv_obs),
      .bus_addr(bus_addr), .share(share), .done(done), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .busy(busy), .err(err)
   );

   typedef struct {
      logic [3:0] g, x, iv, p, ss, sf;
      logic [3:0] e_grant, e_gobs, e_xobs, e_iobs;
      int         e_wr, e_rd, e_done;
      logic       e_share;
      logic [31:0] e_addr;
   } vec_t;

   vec_t v[7];
   int checks = 0;
   int failures = 0;

   int          o_done_cyc, o_rd_cyc, o_wr_cyc, o_rd_n, o_wr_n;
   logic [3:0]  o_grant, o_done, o_gobs, o_xobs, o_iobs;
   logic        o_share, o_stray, o_err2, o_err3;
   logic [31:0] o_addr;

   logic [3:0]  gr[4];
   int          gcyc[4], dcyc[4];
   int          n;
   logic [3:0]  last_g;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_cyc(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual_cycle=%0d expected_cycle=%0d", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      req_gets = '0; req_getx = '0; req_inv = '0; req_putx = '0;
      snoop_share = '0; snoop_flush = '0;
   endtask

   // Inputs applied before edge 0; cycle c is observed at the c-th following negedge.
   task automatic run_txn(input logic [3:0] g, x, iv, p, ss, sf);
      @(negedge clk);
      req_gets = g; req_getx = x; req_inv = iv; req_putx = p;
      snoop_share = ss; snoop_flush = sf;
      o_done_cyc = -1; o_rd_cyc = -1; o_wr_cyc = -1; o_rd_n = 0; o_wr_n = 0;
      o_grant = '0; o_done = '0; o_gobs = '0; o_xobs = '0; o_iobs = '0;
      o_share = 1'b0; o_stray = 1'b0; o_err2 = 1'b0; o_err3 = 1'b0; o_addr = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) begin o_grant = grant; o_addr = bus_addr; end
         if (c == 2) begin
            o_gobs = gets_obs; o_xobs = getx_obs; o_iobs = inv_obs; o_err2 = err;
         end else if ((gets_obs | getx_obs | inv_obs) != 4'b0000) begin
            o_stray = 1'b1;
         end
         if (c == 3) o_err3 = err;
         if (mem_rd) begin o_rd_n++; if (o_rd_cyc < 0) o_rd_cyc = c; end
         if (mem_wr) begin o_wr_n++; if (o_wr_cyc < 0) o_wr_cyc = c; end
         if (done != 4'b0000) begin
            o_done_cyc = c; o_done = done; o_share = share;
            break;
         end
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic wait_done(input string name, input logic [3:0] exp);
      logic [3:0] seen;
      seen = '0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done != 4'b0000) begin seen = done; break; end
      end
      chk(name, seen, exp);
   endtask

   initial begin
      v[0] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
               4'b0010, 4'b1101, 4'b0000, 4'b0000, -1, 4, 8, 1'b0, 32'h1000_0100};
      v[1] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0100,
               4'b0001, 4'b0000, 4'b1110, 4'b0000, 3, FL_RD, FL_DONE, 1'b1, 32'h1000_0000};
      v[2] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0000,
               4'b0100, 4'b0000, 4'b0000, 4'b0000, 2, -1, 6, 1'b0, 32'h1000_0200};
      v[3] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000,
               4'b1000, 4'b0000, 4'b0000, 4'b0111, -1, -1, 4, 1'b1, 32'h1000_0300};
      v[4] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100,
               4'b0100, 4'b1011, 4'b0000, 4'b0000, -1, 4, 8, 1'b0, 32'h1000_0200};
      v[5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1001, 4'b0000,
               4'b0010, 4'b0000, 4'b1101, 4'b0000, -1, 4, 8, 1'b1, 32'h1000_0100};
      v[6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000,
               4'b0001, 4'b1110, 4'b0000, 4'b0000, 3, FL_RD, FL_DONE, 1'b1, 32'h1000_0000};

      for (int i = 0; i < NC; i++) req_addr[i*AW +: AW] = 32'h1000_0000 | (i << 8);
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {grant, gets_obs, getx_obs, inv_obs, done, bus_addr,
                            share, mem_rd, mem_wr, busy, err}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_txn(v[i].g, v[i].x, v[i].iv, v[i].p, v[i].ss, v[i].sf);
         chk($sformatf("v%0d_grant", i), o_grant, v[i].e_grant);
         chk($sformatf("v%0d_addr", i), o_addr, v[i].e_addr);
         chk($sformatf("v%0d_gets_obs", i), o_gobs, v[i].e_gobs);
         chk($sformatf("v%0d_getx_obs", i), o_xobs, v[i].e_xobs);
         chk($sformatf("v%0d_inv_obs", i), o_iobs, v[i].e_iobs);
         chk($sformatf("v%0d_stray_obs", i), o_stray, 1'b0);
         chk_cyc($sformatf("v%0d_mem_wr", i), o_wr_cyc, v[i].e_wr);
         chk_cyc($sformatf("v%0d_mem_rd", i), o_rd_cyc, v[i].e_rd);
         chk($sformatf("v%0d_wr_pulses", i), o_wr_n, (v[i].e_wr >= 0) ? 1 : 0);
         chk($sformatf("v%0d_rd_pulses", i), o_rd_n, (v[i].e_rd >= 0) ? 1 : 0);
         chk_cyc($sformatf("v%0d_done_cycle", i), o_done_cyc, v[i].e_done);
         chk($sformatf("v%0d_done", i), o_done, v[i].e_grant);
         chk($sformatf("v%0d_share", i), o_share, v[i].e_share);
      end
      chk("err_clean", err, 1'b0);

      // Two flushers on one GetS: sticky error, handled as a flush.
      run_txn(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0110);
      chk("err_cycle2", o_err2, 1'b0);
      chk("err_cycle3", o_err3, 1'b1);
      chk_cyc("err_done_cycle", o_done_cyc, FL_DONE);
      chk_cyc("err_mem_wr", o_wr_cyc, 3);
      run_txn(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      chk("err_sticky", err, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      chk("err_cleared", err, 1'b0);
      reset = 1'b1;

      // Round robin from pointer 0 with caches 0, 1, 3 requesting continuously.
      for (int k = 0; k < 4; k++) begin gr[k] = '0; gcyc[k] = -100; dcyc[k] = 0; end
      n = 0; last_g = '0;
      @(negedge clk);
      req_gets = 4'b1011;
      for (int c = 1; c <= 60 && n < 4; c++) begin
         @(negedge clk);
         if (done != 4'b0000 && n > 0) dcyc[n-1] = c;
         if (grant != 4'b0000 && last_g == 4'b0000) begin
            gr[n] = grant; gcyc[n] = c; n++;
         end
         last_g = grant;
      end
      chk("rr_grant0", gr[0], 4'b0001);
      chk("rr_grant1", gr[1], 4'b0010);
      chk("rr_grant2", gr[2], 4'b1000);
      chk("rr_grant3", gr[3], 4'b0001);
      for (int k = 1; k < 4; k++) chk_cyc($sformatf("rr_gap%0d", k), gcyc[k] - dcyc[k-1], 2);
      req_gets = '0;
      wait_done("drop_mid_txn_done", 4'b0001);
      @(negedge clk);

      // Reset during MEM aborts; pending requests restart arbitration at cache 0.
      run_txn(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      req_gets = 4'b1010;
      repeat (5) @(negedge clk);
      chk("rst_pre_grant", grant, 4'b1000);
      chk("rst_pre_busy", busy, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("rst_async_outputs", {grant, gets_obs, getx_obs, inv_obs, done, bus_addr,
                                share, mem_rd, mem_wr, busy, err}, 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst_no_done%0d", c), done, 4'b0000);
      end
      reset = 1'b1;
      last_g = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (grant != 4'b0000) begin last_g = grant; break; end
      end
      chk("rst_regrant", last_g, 4'b0010);
      req_gets = '0;
      wait_done("rst_regrant_done", 4'b0010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
